// File: rtl/pick_ball_scheduler.sv
// pick_ball_scheduler: time-shares one rotation LUT among the beads of the
// rotating pick. On frame_start it snapshots the pick geometry, sweeps the
// bead radii through the LUT one per cycle and caches each bead centre.
// During active video it hit-tests the current pixel against the cached centres.
//
// Ports:
//   CLK, Reset            clock, synchronous active-high reset
//   frame_start           one-cycle pulse at start of vertical blanking
//   centerX/centerY       pick pivot
//   radius, PickY         outer bead radius, angle selector
//   drawX/drawY           current pixel
//   lut_req, lut_*        request side of the shared rotation LUT
//   lut_rotx/lut_roty     LUT result, valid LUT_LATENCY cycles after lut_req
//   busy                  sweep in progress
//   showPick              registered hit flag (1-cycle latency from drawX/drawY)
//
// Build option: define PICK_DOUBLE_BUFFER_EN to sweep into a shadow bank that
// is copied to the display bank when the sweep completes.
module pick_ball_scheduler #(
   parameter int unsigned NUM_BALLS   = 10,
   parameter int unsigned RADIUS_STEP = 10,
   parameter int unsigned BALL_R2     = 121,
   parameter int unsigned LUT_LATENCY = 1
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       frame_start,
   input  logic [9:0] centerX,
   input  logic [9:0] centerY,
   input  logic [9:0] radius,
   input  logic [9:0] PickY,
   input  logic [9:0] drawX,
   input  logic [9:0] drawY,
   output logic       lut_req,
   output logic [9:0] lut_centerX,
   output logic [9:0] lut_centerY,
   output logic [9:0] lut_radius,
   output logic [9:0] lut_pick_y,
   input  logic [9:0] lut_rotx,
   input  logic [9:0] lut_roty,
   output logic       busy,
   output logic       showPick
);

   localparam int unsigned K_W   = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
   localparam int unsigned D_W   = $clog2(LUT_LATENCY + 1);
   localparam int unsigned OFF_W = 16;

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
   } bead_t;

   state_t           state, state_nxt;
   logic [K_W-1:0]   k, k_nxt;
   logic [OFF_W-1:0] off, off_nxt;
   logic [D_W-1:0]   drain_cnt, drain_nxt;
   logic             ld_snap, swap;
   logic [9:0]       r_snap, r_src, radius_nxt;
   logic             req_nxt;

   // State register
   always_ff @(posedge CLK) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state, slot counter and next LUT request (outputs are registered,
   // so the request for the slot entered next cycle is formed here)
   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      off_nxt   = off;
      drain_nxt = drain_cnt;
      ld_snap   = 1'b0;
      swap      = 1'b0;
      unique case (state)
         IDLE: begin
            if (frame_start) begin
               state_nxt = SWEEP;
               k_nxt     = '0;
               off_nxt   = '0;
               ld_snap   = 1'b1;
            end
         end
         SWEEP: begin
            if (k == K_W'(NUM_BALLS - 1)) begin
               state_nxt = DRAIN;
               drain_nxt = '0;
            end else begin
               k_nxt   = k + K_W'(1);
               off_nxt = off + OFF_W'(RADIUS_STEP);
            end
         end
         DRAIN: begin
            if (drain_cnt == D_W'(LUT_LATENCY - 1)) begin
               state_nxt = IDLE;
               swap      = 1'b1;
            end else begin
               drain_nxt = drain_cnt + D_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
      r_src      = ld_snap ? radius : r_snap;
      // Beads whose offset exceeds the radius would sit past the pivot: disabled
      req_nxt    = (state_nxt == SWEEP) && (OFF_W'(r_src) >= off_nxt);
      radius_nxt = (state_nxt == SWEEP) ? 10'(OFF_W'(r_src) - off_nxt) : lut_radius;
   end

   // Counters, snapshots and LUT request outputs
   always_ff @(posedge CLK) begin
      if (Reset) begin
         k           <= '0;
         off         <= '0;
         drain_cnt   <= '0;
         r_snap      <= '0;
         lut_centerX <= '0;
         lut_centerY <= '0;
         lut_pick_y  <= '0;
         lut_req     <= 1'b0;
         lut_radius  <= '0;
         busy        <= 1'b0;
      end else begin
         k          <= k_nxt;
         off        <= off_nxt;
         drain_cnt  <= drain_nxt;
         lut_req    <= req_nxt;
         lut_radius <= radius_nxt;
         busy       <= (state_nxt != IDLE);
         if (ld_snap) begin
            r_snap      <= radius;
            lut_centerX <= centerX;
            lut_centerY <= centerY;
            lut_pick_y  <= PickY;
         end
      end
   end

   // Slot tracking pipe aligned with the LUT latency
   logic [LUT_LATENCY-1:0] pipe_live, pipe_req;
   logic [K_W-1:0]         pipe_k [LUT_LATENCY];
   logic                   ex_live, ex_req;
   logic [K_W-1:0]         ex_k;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         pipe_live <= '0;
         pipe_req  <= '0;
         for (int i = 0; i < LUT_LATENCY; i++) pipe_k[i] <= '0;
      end else begin
         pipe_live[0] <= (state == SWEEP);
         pipe_req[0]  <= lut_req;
         pipe_k[0]    <= k;
         for (int i = 1; i < LUT_LATENCY; i++) begin
            pipe_live[i] <= pipe_live[i-1];
            pipe_req[i]  <= pipe_req[i-1];
            pipe_k[i]    <= pipe_k[i-1];
         end
      end
   end

   assign ex_live = pipe_live[LUT_LATENCY-1];
   assign ex_req  = pipe_req[LUT_LATENCY-1];
   assign ex_k    = pipe_k[LUT_LATENCY-1];

   // Working bank: cleared on sweep entry, written as slots leave the pipe
   bead_t                work [NUM_BALLS];
   bead_t                work_nxt [NUM_BALLS];
   logic [NUM_BALLS-1:0] work_v, work_v_nxt;

   always_comb begin
      work_nxt   = work;
      work_v_nxt = work_v;
      if (ld_snap) work_v_nxt = '0;
      if (ex_live) begin
         work_nxt[ex_k]   = '{x: lut_rotx, y: lut_roty};
         work_v_nxt[ex_k] = ex_req;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) work_v <= '0;
      else       work_v <= work_v_nxt;
   end

   always_ff @(posedge CLK) begin
      work <= work_nxt;
   end

   // Display bank seen by the hit test
   bead_t                disp [NUM_BALLS];
   logic [NUM_BALLS-1:0] disp_v;

`ifdef PICK_DOUBLE_BUFFER_EN
   // Copy includes the final slot written on the same edge
   always_ff @(posedge CLK) begin
      if (Reset)     disp_v <= '0;
      else if (swap) disp_v <= work_v_nxt;
   end

   always_ff @(posedge CLK) begin
      if (swap) disp <= work_nxt;
   end
`else
   always_comb begin
      disp   = work;
      disp_v = work_v;
   end
`endif

   // Squared-distance test of one pixel against one bead centre
   function automatic logic bead_hit(input logic [9:0] px, input logic [9:0] py,
                                     input bead_t b);
      logic signed [10:0] dx, dy;
      logic [9:0]         ax, ay;
      logic [20:0]        d2;
      dx = $signed({1'b0, px}) - $signed({1'b0, b.x});
      dy = $signed({1'b0, py}) - $signed({1'b0, b.y});
      ax = dx[10] ? 10'(-dx) : 10'(dx);
      ay = dy[10] ? 10'(-dy) : 10'(dy);
      d2 = 21'(20'(ax) * 20'(ax)) + 21'(20'(ay) * 20'(ay));
      return (d2 <= 21'(BALL_R2));
   endfunction

   logic hit_any;

   always_comb begin
      hit_any = 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) begin
         if (disp_v[i] && bead_hit(drawX, drawY, disp[i])) hit_any = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) showPick <= 1'b0;
      else       showPick <= hit_any;
   end

endmodule

// File: tb/tb_pick_ball_scheduler.sv
// Bench for pick_ball_scheduler: LUT model rotx = centerX + r, roty = centerY
// with one cycle of latency; expected LUT radii and hit flags are queued when
// driven and compared when the DUT produces them.
module tb_pick_ball_scheduler;

   localparam int N    = 10;
   localparam int STEP = 10;

   logic       CLK = 1'b0;
   logic       Reset, frame_start;
   logic [9:0] centerX, centerY, radius, PickY, drawX, drawY;
   logic       lut_req, busy, showPick;
   logic [9:0] lut_centerX, lut_centerY, lut_radius, lut_pick_y;
   logic [9:0] lut_rotx = '0;
   logic [9:0] lut_roty = '0;

   int checks = 0;
   int errors = 0;
   int rad_q[$];
   bit hit_q[$];

   pick_ball_scheduler dut (
      .CLK(CLK), .Reset(Reset), .frame_start(frame_start),
      .centerX(centerX), .centerY(centerY), .radius(radius), .PickY(PickY),
      .drawX(drawX), .drawY(drawY),
      .lut_req(lut_req), .lut_centerX(lut_centerX), .lut_centerY(lut_centerY),
      .lut_radius(lut_radius), .lut_pick_y(lut_pick_y),
      .lut_rotx(lut_rotx), .lut_roty(lut_roty),
      .busy(busy), .showPick(showPick)
   );

   always #5 CLK = ~CLK;

   // Rotation LUT model, one cycle latency
   always @(posedge CLK) begin
      if (lut_req) begin
         lut_rotx <= 10'(lut_centerX + lut_radius);
         lut_roty <= lut_centerY;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Pixel hit test: showPick is registered one cycle after the pixel
   task automatic hit(input string tag, input int x, input int y, input bit e);
      drawX = 10'(x);
      drawY = 10'(y);
      hit_q.push_back(e);
      tick();
      @(negedge CLK);
      check(tag, 32'(showPick), 32'(hit_q.pop_front()));
   endtask

   // Full sweep; optional colliding frame_start at busy cycle index collide_at
   task automatic run_sweep(input int cx, input int cy, input int r, input int collide_at);
      int busy_n;
      int slot;
      for (int k = 0; k < N; k++) if (r >= STEP * k) rad_q.push_back(r - STEP * k);
      centerX = 10'(cx);
      centerY = 10'(cy);
      radius  = 10'(r);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      busy_n = 0;
      slot   = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (!busy) break;
         busy_n++;
         if (slot < N) check("req_slot", 32'(lut_req), 32'(r >= STEP * slot));
         slot++;
         if (lut_req) begin
            if (rad_q.size() == 0) check("req_extra", 32'(lut_req), 32'(0));
            else                   check("lut_radius", 32'(lut_radius), 32'(rad_q.pop_front()));
         end
         if (c == collide_at) begin
            centerX     = 10'd100;
            radius      = 10'd50;
            frame_start = 1'b1;
         end else begin
            frame_start = 1'b0;
         end
         tick();
      end
      frame_start = 1'b0;
      check("busy_len", 32'(busy_n), 32'(N + 1));
      check("radius_q_empty", 32'(rad_q.size()), 32'(0));
      check("snap_cx", 32'(lut_centerX), 32'(cx));
      rad_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      Reset = 1'b1;
      frame_start = 1'b0;
      centerX = '0; centerY = '0; radius = '0; PickY = 10'd7;
      drawX = '0; drawY = '0;
      repeat (3) tick();
      @(negedge CLK);
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_show", 32'(showPick), 32'(0));
      check("rst_req", 32'(lut_req), 32'(0));
      check("rst_radius", 32'(lut_radius), 32'(0));
      check("rst_cx", 32'(lut_centerX), 32'(0));
      tick();
      Reset = 1'b0;
      tick();

      // Sweep timing, radius 100: beads at X = 420 .. 330, Y = 240
      run_sweep(320, 240, 100, -1);
      check("snap_pick_y", 32'(lut_pick_y), 32'(7));
      hit("hit_bead0", 425, 240, 1'b1);
      hit("miss_12px", 432, 240, 1'b0);
      hit("edge_r2", 330, 251, 1'b1);
      hit("miss_far", 300, 240, 1'b0);

      // Underflow, radius 35: beads at 355, 345, 335, 325 only
      run_sweep(320, 240, 35, -1);
      hit("uf_hit", 325, 240, 1'b1);
      hit("uf_stale", 380, 240, 1'b0);
      hit("uf_stale9", 420, 240, 1'b0);

      // Collision: second frame_start ignored, first snapshot kept
      run_sweep(320, 240, 100, 3);
      check("coll_cy", 32'(lut_centerY), 32'(240));
      hit("coll_hit", 425, 240, 1'b1);
      hit("coll_hit9", 330, 240, 1'b1);

      // Reset at sweep cycle 5
      drawX = 10'd420;
      drawY = 10'd240;
      radius = 10'd100;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (4) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      @(negedge CLK);
      check("mid_rst_busy", 32'(busy), 32'(0));
      check("mid_rst_show", 32'(showPick), 32'(0));
      check("mid_rst_req", 32'(lut_req), 32'(0));
      for (int i = 0; i < 3; i++) hit("mid_rst_hold", 420, 240, 1'b0);
      run_sweep(320, 240, 100, -1);
      hit("post_rst_hit", 420, 240, 1'b1);

      // Buffering: hold pixel on bead 0 of the radius-100 sweep, resweep at 50
      tick();
      check("buf_pre", 32'(showPick), 32'(1));
      radius = 10'd50;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge CLK);
`ifdef PICK_DOUBLE_BUFFER_EN
         check("buf_show", 32'(showPick), 32'(c <= 12));
`else
         check("buf_show", 32'(showPick), 32'(c == 1));
`endif
         tick();
      end
      check("buf_idle", 32'(busy), 32'(0));
      hit("buf_new_bead", 370, 240, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pick_ball_scheduler.md
Name: pick_ball_scheduler

Overview:
- Time-shares one rotation lookup (the rotational_motion LUT) among the NUM_BALLS beads of the rotating pick, instead of instantiating one LUT per bead.
- At each frame_start it snapshots the pick geometry and sweeps the bead radii through the shared LUT, one per cycle, caching each bead's centre in a register bank.
- During active video it hit-tests drawX/drawY against the cached centres and produces a registered showPick for the colour mapper.

Parameters:
- NUM_BALLS, 10, number of beads on the pick (bead k at radius - k*RADIUS_STEP).
- RADIUS_STEP, 10, radial spacing between beads, pixels.
- BALL_R2, 121, bead radius squared (hit if dist² <= BALL_R2).
- LUT_LATENCY, 1, cycles from lut_req to valid lut_rotx/lut_roty (>=1).

Ports:
- CLK  in  1  system clock
- Reset  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- centerX  in  10  pick pivot X
- centerY  in  10  pick pivot Y
- radius  in  10  outer bead radius
- PickY  in  10  angle/phase selector forwarded to LUT
- drawX  in  10  current pixel X
- drawY  in  10  current pixel Y
- lut_req  out  1  LUT request strobe
- lut_centerX  out  10  snapshot centerX to LUT
- lut_centerY  out  10  snapshot centerY to LUT
- lut_radius  out  10  bead radius for this request
- lut_pick_y  out  10  snapshot PickY to LUT
- lut_rotx  in  10  LUT result X, valid LUT_LATENCY cycles after lut_req
- lut_roty  in  10  LUT result Y
- busy  out  1  sweep in progress
- showPick  out  1  current pixel lies inside any valid bead

Behaviour:
- Reset: all outputs 0; FSM to IDLE; all bead valid bits 0; k counter 0; latency pipe cleared. Reset mid-sweep aborts the sweep with no partial writes kept.
- States: IDLE, SWEEP, DRAIN.
- IDLE: on frame_start, snapshot centerX/centerY/radius/PickY, set k=0, and go to SWEEP. busy rises the next cycle.
- SWEEP: one slot per cycle for k = 0..NUM_BALLS-1, always NUM_BALLS cycles.
  - Slot k drives lut_radius = radius_snap - k*RADIUS_STEP.
  - lut_req = 1 only if radius_snap >= k*RADIUS_STEP. Otherwise the bead is disabled: no request, and its valid bit is written 0 when that slot exits the pipe.
  - {k, req} enters a LUT_LATENCY-deep shift pipe. On exit with req=1, store lut_rotx/lut_roty into bank[k] and set valid[k]=1.
  - After the last slot, go to DRAIN.
- DRAIN: wait LUT_LATENCY cycles for the pipe to empty, then go to IDLE.
- busy: high from the cycle after frame_start through the last DRAIN cycle, i.e. NUM_BALLS + LUT_LATENCY cycles.
- frame_start while busy: ignored; no restart and no queueing.
- Hit test: combinational over all beads, then registered, so showPick has 1-cycle latency from drawX/drawY.
  - dx = drawX - bead X and dy = drawY - bead Y, as 11-bit signed values.
  - dx² and dy² are unsigned 20-bit; the sum is 21-bit; compare <= BALL_R2.
  - showPick = OR over k of (valid[k] && hit[k]).
- lut_centerX, lut_centerY and lut_pick_y hold their snapshot values between sweeps.

Optional Feature:
- Macro: PICK_DOUBLE_BUFFER_EN.
- Defined:
  - Sweep writes go to a shadow bank plus shadow valid bits.
  - On the DRAIN→IDLE transition, the shadow is copied to the display bank in one cycle.
  - showPick always reflects a complete previous sweep and is never blanked mid-sweep.
- Undefined:
  - Single bank; all valid bits are cleared on the cycle SWEEP is entered.
  - Beads reappear individually as written.
  - showPick may be 0 for beads not yet rewritten during the sweep.

Test Plan:
1. Sweep timing. Bench LUT model: rotx = centerX + r, roty = centerY; LUT_LATENCY = 1. Stimulus: centerX=320, centerY=240, radius=100, frame_start pulse. Required: busy high exactly 11 cycles; lut_radius sequence 100, 90, …, 10; lut_req high all 10 slots.
2. Hit detection, after sweep 1.
   - drawX=425, drawY=240 → showPick=1 one cycle later (bead 9 at 330? no, bead 0 at 420, dist 5).
   - drawX=432, drawY=240 → showPick=0 (dist 12, 144 > 121).
   - drawX=330, drawY=251 → showPick=1 (bead 9, dist² = 121 boundary).
3. Underflow. Stimulus: radius=35. Required: lut_req high only for slots 0–3, with radii 35, 25, 15, 5; valid[4..9] = 0; drawX=325, drawY=240 → showPick=1.
4. Collision. Stimulus: second frame_start 4 cycles into a sweep. Required: ignored; busy still drops after 11 cycles total; bank holds the first snapshot's values.
5. Reset mid-sweep. Stimulus: Reset asserted at sweep cycle 5. Required: next cycle busy=0, showPick=0, lut_req=0; drawX=420, drawY=240 → showPick stays 0 until a new sweep completes.
6. Buffering. Sweep 1 with radius=100, then sweep 2 with radius=50; during sweep 2 hold drawX=420, drawY=240.
   - With PICK_DOUBLE_BUFFER_EN: showPick stays 1 until swap, then 0.
   - Without it: showPick drops to 0 the cycle after SWEEP entry.
